// File: rtl/plic_reg_arbiter.sv
// Round-robin sequencer sharing the PLIC register port among NUM_REQ requesters,
// with local rejection of out-of-window accesses and a BUSY timeout.
module plic_reg_arbiter #(
  parameter int unsigned           NUM_REQ        = 2,
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 'h0400_0000,
  parameter logic [ADDR_WIDTH-1:0] WINDOW_SIZE    = 'h0400_0000,
  parameter int unsigned           TIMEOUT_CYCLES = 256
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  input  logic [NUM_REQ-1:0]                 req_write_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata_i,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]  req_wstrb_i,
  output logic [NUM_REQ-1:0]                 rsp_ready_o,
  output logic [DATA_WIDTH-1:0]              rsp_rdata_o,
  output logic                               rsp_error_o,
  output logic                               m_valid_o,
  output logic                               m_write_o,
  output logic [ADDR_WIDTH-1:0]              m_addr_o,
  output logic [DATA_WIDTH-1:0]              m_wdata_o,
  output logic [DATA_WIDTH/8-1:0]            m_wstrb_o,
  input  logic [DATA_WIDTH-1:0]              m_rdata_i,
  input  logic                               m_error_i,
  input  logic                               m_ready_i,
  output logic [NUM_REQ-1:0]                 grant_o,
  output logic                               busy_o,
  output logic                               timeout_o
);

  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, BUSY, LOCAL_ERR} state_t;

  state_t              state;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       owner;
  logic [PW-1:0]       win;
  logic [PW-1:0]       next_ptr;
  logic [NUM_REQ-1:0]  win_onehot;
  logic [NUM_REQ-1:0]  grant;
  logic [CW-1:0]       cnt;
  logic                found;
  int unsigned         idx;
  logic                sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [SW-1:0]       sel_wstrb;
  logic                sel_in_window;
  logic                tmo_hit;

  // Rotating search: first asserted valid at or after ptr, modulo NUM_REQ.
  always_comb begin
    found      = 1'b0;
    win        = '0;
    idx        = 0;
    win_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!found && req_valid_i[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
    win_onehot[win] = 1'b1;
    sel_write     = req_write_i[win];
    sel_addr      = req_addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata     = req_wdata_i[win*DATA_WIDTH +: DATA_WIDTH];
    sel_wstrb     = req_wstrb_i[win*SW +: SW];
    sel_in_window = (sel_addr >= BASE_ADDR) && ((sel_addr - BASE_ADDR) < WINDOW_SIZE);
  end

  assign next_ptr = (owner == LAST_IDX) ? '0 : owner + 1'b1;
  assign tmo_hit  = (state == BUSY) && !m_ready_i && (cnt == CNT_LAST);

  assign m_valid_o = (state == BUSY);
  assign busy_o    = (state != IDLE);
  assign grant_o   = grant;

  // Response path is combinational so a zero-wait slave completes in its first BUSY cycle.
  always_comb begin
    rsp_ready_o = '0;
    rsp_rdata_o = '0;
    rsp_error_o = 1'b0;
    timeout_o   = 1'b0;
    case (state)
      BUSY: begin
        if (m_ready_i) begin
          rsp_ready_o = grant;
          rsp_rdata_o = m_rdata_i;
          rsp_error_o = m_error_i;
        end else if (tmo_hit) begin
          rsp_ready_o = grant;
          rsp_error_o = 1'b1;
          timeout_o   = 1'b1;
        end
      end
      LOCAL_ERR: begin
        rsp_ready_o = grant;
        rsp_error_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      grant     <= '0;
      cnt       <= '0;
      m_write_o <= 1'b0;
      m_addr_o  <= '0;
      m_wdata_o <= '0;
      m_wstrb_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (found) begin
            grant     <= win_onehot;
            owner     <= win;
            m_write_o <= sel_write;
            m_addr_o  <= sel_addr - BASE_ADDR;
            m_wdata_o <= sel_wdata;
            m_wstrb_o <= sel_wstrb;
            state     <= sel_in_window ? BUSY : LOCAL_ERR;
          end
        end
        BUSY: begin
          if (m_ready_i || (cnt == CNT_LAST)) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= next_ptr;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOCAL_ERR: begin
          state <= IDLE;
          grant <= '0;
          ptr   <= next_ptr;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plic_reg_arbiter.sv
// Self-checking bench for plic_reg_arbiter: directed vector table, reset/fairness
// sequences and randomized transactions against a transaction-level model.
module tb_plic_reg_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned TMO  = 8;
  localparam longint unsigned BASE = 64'h0400_0000;
  localparam longint unsigned WIN  = 64'h0400_0000;

  logic                 clk_i;
  logic                 rst_ni;
  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ-1:0]      req_write_i;
  logic [NREQ*AW-1:0]   req_addr_i;
  logic [NREQ*DW-1:0]   req_wdata_i;
  logic [NREQ*DW/8-1:0] req_wstrb_i;
  logic [NREQ-1:0]      rsp_ready_o;
  logic [DW-1:0]        rsp_rdata_o;
  logic                 rsp_error_o;
  logic                 m_valid_o;
  logic                 m_write_o;
  logic [AW-1:0]        m_addr_o;
  logic [DW-1:0]        m_wdata_o;
  logic [DW/8-1:0]      m_wstrb_o;
  logic [DW-1:0]        m_rdata_i;
  logic                 m_error_i;
  logic                 m_ready_i;
  logic [NREQ-1:0]      grant_o;
  logic                 busy_o;
  logic                 timeout_o;

  plic_reg_arbiter #(
    .NUM_REQ       (NREQ),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .BASE_ADDR     (32'h0400_0000),
    .WINDOW_SIZE   (32'h0400_0000),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_valid_i(req_valid_i),
    .req_write_i(req_write_i),
    .req_addr_i (req_addr_i),
    .req_wdata_i(req_wdata_i),
    .req_wstrb_i(req_wstrb_i),
    .rsp_ready_o(rsp_ready_o),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_error_o(rsp_error_o),
    .m_valid_o  (m_valid_o),
    .m_write_o  (m_write_o),
    .m_addr_o   (m_addr_o),
    .m_wdata_o  (m_wdata_o),
    .m_wstrb_o  (m_wstrb_o),
    .m_rdata_i  (m_rdata_i),
    .m_error_i  (m_error_i),
    .m_ready_i  (m_ready_i),
    .grant_o    (grant_o),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  wr;
    logic [31:0] a0;
    logic [31:0] a1;
    int          wait_c;
    logic        serr;
    logic [31:0] srdata;
    int          exp_win;
    logic        exp_local;
    int          exp_cyc;
    logic        exp_err;
    logic        exp_to;
    logic [31:0] exp_maddr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    longint unsigned x = 64'(a);
    return (x >= BASE) && (x < BASE + WIN);
  endfunction

  // One complete transaction starting from IDLE; ends at the negedge of the completion cycle.
  task automatic run_txn(input logic [1:0] valid, input logic [1:0] wr,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input int wait_c, input logic serr, input logic [31:0] srdata,
                         input int exp_win, input logic exp_local, input int exp_cyc,
                         input logic exp_err, input logic exp_to,
                         input logic [31:0] exp_maddr, input logic [31:0] exp_rdata);
    logic [31:0] wd[2];
    logic [3:0]  ws[2];
    logic [1:0]  oh;
    oh = 2'(1 << exp_win);
    wd[0] = $urandom; wd[1] = $urandom;
    ws[0] = 4'($urandom); ws[1] = 4'($urandom);
    @(posedge clk_i); #1;
    req_valid_i = valid;
    req_write_i = wr;
    req_addr_i  = {a1, a0};
    req_wdata_i = {wd[1], wd[0]};
    req_wstrb_i = {ws[1], ws[0]};
    m_ready_i   = 1'b0;
    m_rdata_i   = $urandom;
    m_error_i   = 1'($urandom);
    @(negedge clk_i);
    chk("idle_busy", 64'(busy_o), 64'(0));
    chk("idle_grant", 64'(grant_o), 64'(0));
    chk("idle_rsp_ready", 64'(rsp_ready_o), 64'(0));
    for (int c = 1; c <= exp_cyc; c++) begin
      @(posedge clk_i); #1;
      // Payload changes after the grant must be ignored.
      req_write_i = 2'($urandom);
      req_addr_i  = {$urandom, $urandom};
      req_wdata_i = {$urandom, $urandom};
      req_wstrb_i = 8'($urandom);
      if (!exp_local && c == wait_c + 1) begin
        m_ready_i = 1'b1;
        m_rdata_i = srdata;
        m_error_i = serr;
      end else begin
        m_ready_i = 1'b0;
        m_rdata_i = $urandom;
        m_error_i = 1'($urandom);
      end
      @(negedge clk_i);
      chk("grant", 64'(grant_o), 64'(oh));
      chk("busy", 64'(busy_o), 64'(1));
      chk("m_valid", 64'(m_valid_o), 64'(!exp_local));
      if (!exp_local) begin
        chk("m_addr", 64'(m_addr_o), 64'(exp_maddr));
        chk("m_write", 64'(m_write_o), 64'(wr[exp_win]));
        chk("m_wdata", 64'(m_wdata_o), 64'(wd[exp_win]));
        chk("m_wstrb", 64'(m_wstrb_o), 64'(ws[exp_win]));
      end
      if (c == exp_cyc) begin
        chk("rsp_ready", 64'(rsp_ready_o), 64'(oh));
        chk("rsp_error", 64'(rsp_error_o), 64'(exp_err));
        chk("rsp_rdata", 64'(rsp_rdata_o), 64'(exp_rdata));
        chk("timeout", 64'(timeout_o), 64'(exp_to));
      end else begin
        chk("rsp_ready_quiet", 64'(rsp_ready_o), 64'(0));
        chk("rsp_error_quiet", 64'(rsp_error_o), 64'(0));
        chk("rsp_rdata_quiet", 64'(rsp_rdata_o), 64'(0));
        chk("timeout_quiet", 64'(timeout_o), 64'(0));
      end
    end
    mptr = (exp_win + 1) % NREQ;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0: return 32'(BASE) + ($urandom_range(0, 32'h03FF_FFFF) & 32'hFFFF_FFFC);
      1: return $urandom_range(0, 32'h03FF_FFFF);
      2: return 32'h0800_0000 + $urandom_range(0, 32'h1000);
      3: return 32'h07FF_FFFF;
      default: return 32'(BASE);
    endcase
  endfunction

  initial begin
    rst_ni      = 1'b0;
    req_valid_i = '0;
    req_write_i = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_wstrb_i = '0;
    m_rdata_i   = '0;
    m_error_i   = 1'b0;
    m_ready_i   = 1'b0;

    tbl[0]  = '{2'b01, 2'b00, 32'h0400_0004, 32'h0,         0,   1'b0, 32'hDEAD_BEEF, 0, 1'b0, 1, 1'b0, 1'b0, 32'h4,         32'hDEAD_BEEF};
    tbl[1]  = '{2'b11, 2'b00, 32'h0400_0010, 32'h0400_0020, 0,   1'b0, 32'h1111_1111, 1, 1'b0, 1, 1'b0, 1'b0, 32'h20,        32'h1111_1111};
    tbl[2]  = '{2'b11, 2'b00, 32'h0400_0010, 32'h0400_0020, 2,   1'b0, 32'h1234_5678, 0, 1'b0, 3, 1'b0, 1'b0, 32'h10,        32'h1234_5678};
    tbl[3]  = '{2'b11, 2'b11, 32'h0400_0010, 32'h0400_0020, 0,   1'b0, 32'h0,         1, 1'b0, 1, 1'b0, 1'b0, 32'h20,        32'h0};
    tbl[4]  = '{2'b10, 2'b10, 32'h0,         32'h0800_0000, 0,   1'b0, 32'h0,         1, 1'b1, 1, 1'b1, 1'b0, 32'h0,         32'h0};
    tbl[5]  = '{2'b01, 2'b01, 32'h0400_0100, 32'h0,         3,   1'b1, 32'hAAAA_5555, 0, 1'b0, 4, 1'b1, 1'b0, 32'h100,       32'hAAAA_5555};
    tbl[6]  = '{2'b10, 2'b00, 32'h0,         32'h0400_0008, 100, 1'b0, 32'h0,         1, 1'b0, 8, 1'b1, 1'b1, 32'h8,         32'h0};
    tbl[7]  = '{2'b01, 2'b00, 32'h0400_000C, 32'h0,         7,   1'b0, 32'hCAFE_F00D, 0, 1'b0, 8, 1'b0, 1'b0, 32'hC,         32'hCAFE_F00D};
    tbl[8]  = '{2'b01, 2'b00, 32'h03FF_FFFC, 32'h0,         0,   1'b0, 32'h0,         0, 1'b1, 1, 1'b1, 1'b0, 32'h0,         32'h0};
    tbl[9]  = '{2'b11, 2'b00, 32'h07FF_FFFC, 32'h0400_0000, 0,   1'b0, 32'h5A5A_5A5A, 1, 1'b0, 1, 1'b0, 1'b0, 32'h0,         32'h5A5A_5A5A};
    tbl[10] = '{2'b01, 2'b00, 32'h07FF_FFFC, 32'h0,         0,   1'b0, 32'h0F0F_0F0F, 0, 1'b0, 1, 1'b0, 1'b0, 32'h03FF_FFFC, 32'h0F0F_0F0F};
    tbl[11] = '{2'b10, 2'b00, 32'h0,         32'h07FF_FFFF, 0,   1'b0, 32'h7777_0000, 1, 1'b0, 1, 1'b0, 1'b0, 32'h03FF_FFFF, 32'h7777_0000};

    #12;
    chk("rst_grant", 64'(grant_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_m_valid", 64'(m_valid_o), 64'(0));
    chk("rst_m_write", 64'(m_write_o), 64'(0));
    chk("rst_m_addr", 64'(m_addr_o), 64'(0));
    chk("rst_m_wdata", 64'(m_wdata_o), 64'(0));
    chk("rst_m_wstrb", 64'(m_wstrb_o), 64'(0));
    chk("rst_rsp_ready", 64'(rsp_ready_o), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata_o), 64'(0));
    chk("rst_rsp_error", 64'(rsp_error_o), 64'(0));
    chk("rst_timeout", 64'(timeout_o), 64'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_txn(tbl[i].valid, tbl[i].wr, tbl[i].a0, tbl[i].a1, tbl[i].wait_c, tbl[i].serr,
              tbl[i].srdata, tbl[i].exp_win, tbl[i].exp_local, tbl[i].exp_cyc,
              tbl[i].exp_err, tbl[i].exp_to, tbl[i].exp_maddr, tbl[i].exp_rdata);
    end

    // Reset in cycle 2 of a stalled transaction.
    @(posedge clk_i); #1;
    req_valid_i = 2'b10;
    req_write_i = 2'b00;
    req_addr_i  = {32'h0400_0040, 32'h0400_0044};
    m_ready_i   = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("stall_m_valid", 64'(m_valid_o), 64'(1));
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_m_valid", 64'(m_valid_o), 64'(0));
    chk("arst_grant", 64'(grant_o), 64'(0));
    chk("arst_busy", 64'(busy_o), 64'(0));
    chk("arst_rsp_ready", 64'(rsp_ready_o), 64'(0));
    chk("arst_m_addr", 64'(m_addr_o), 64'(0));
    req_valid_i = '0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    mptr = 0;

    // Fairness from reset: both requesters held valid.
    for (int k = 0; k < 4; k++) begin
      run_txn(2'b11, 2'b00, 32'h0400_0200, 32'h0400_0300, 0, 1'b0, 32'h100 + 32'(k),
              k % 2, 1'b0, 1, 1'b0, 1'b0, (k % 2 == 0) ? 32'h200 : 32'h300, 32'h100 + 32'(k));
    end

    for (int k = 0; k < 40; k++) begin
      logic [1:0]  v;
      logic [1:0]  w;
      logic [31:0] a[2];
      int          wt;
      int          win;
      int          cyc;
      logic        se;
      logic [31:0] sd;
      logic        loc;
      logic        to;
      v    = 2'($urandom_range(1, 3));
      w    = 2'($urandom);
      a[0] = rand_addr();
      a[1] = rand_addr();
      wt   = $urandom_range(0, 10);
      se   = 1'($urandom);
      sd   = $urandom;
      win  = v[mptr] ? mptr : (mptr + 1) % NREQ;
      loc  = !in_window(a[win]);
      to   = !loc && (wt + 1 > TMO);
      cyc  = loc ? 1 : (to ? TMO : wt + 1);
      run_txn(v, w, a[0], a[1], wt, se, sd, win, loc, cyc,
              loc || to || se, to, a[win] - 32'(BASE), (loc || to) ? 32'h0 : sd);
    end

    @(posedge clk_i); #1;
    req_valid_i = '0;
    m_ready_i   = 1'b0;
    @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
